capture_ram: RTL and testbench

CAPTURE_RAM -- requirements
Module: capture_ram

---
 rtl/capture_ram.sv | 174 +++++++++++++++++
 tb/tb_capture_ram.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ram.sv
// Sample capture buffer: one-shot fill or circular pre/post-trigger capture into a read-first RAM.
// Optional macro CAPTURE_RAM_OREG_EN adds a reset output register on the read path (latency 2).
module capture_ram #(
    parameter int unsigned RAM_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 16,
    parameter int unsigned POST_DEPTH    = 2**(RAM_ADDR_BITS-1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     mode,
    input  logic                     trigger,
    input  logic                     sample_valid,
    input  logic [RAM_WIDTH-1:0]     sample_data,
    input  logic                     read_enable,
    input  logic [RAM_ADDR_BITS-1:0] read_address,
    output logic [RAM_WIDTH-1:0]     read_data,
    output logic                     read_valid,
    output logic                     busy,
    output logic                     done,
    output logic [RAM_ADDR_BITS-1:0] wr_addr,
    output logic [RAM_ADDR_BITS-1:0] trig_addr,
    output logic                     wrapped
);

    localparam int unsigned Depth = 2**RAM_ADDR_BITS;
    localparam int unsigned CntW  = RAM_ADDR_BITS + 1;

    typedef enum logic [2:0] {StIdle, StFill, StPre, StPost, StDone} state_e;

    state_e                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [RAM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [RAM_ADDR_BITS-1:0] trig_addr_q, trig_addr_d;
    logic                     wrapped_q, wrapped_d;
    logic [CntW-1:0]          post_cnt_q, post_cnt_d;
    logic                     busy_q, done_q;
    logic [RAM_WIDTH-1:0]     rd_data_q;
    logic                     rd_valid_q;

    logic [RAM_WIDTH-1:0]     mem [Depth];

    logic capturing, we, at_top;

    assign capturing = (state_q == StFill) || (state_q == StPre) || (state_q == StPost);
    assign we        = capturing && sample_valid && !abort;
    assign at_top    = (wr_addr_q == {RAM_ADDR_BITS{1'b1}});

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_addr_d   = wr_addr_q;
        trig_addr_d = trig_addr_q;
        wrapped_d   = wrapped_q;
        post_cnt_d  = post_cnt_q;

        if (we) begin
            wr_addr_d = wr_addr_q + RAM_ADDR_BITS'(1);
            if (at_top) begin
                wrapped_d = 1'b1;
            end
        end

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        wr_addr_d = '0;
                        wrapped_d = 1'b0;
                        mode_d    = mode;
                        state_d   = mode ? StPre : StFill;
                    end
                end
                StFill: begin
                    if (we && at_top) begin
                        state_d = StDone;
                    end
                end
                StPre: begin
                    if (trigger && mode_q) begin
                        trig_addr_d = wr_addr_q;
                        // A valid trigger-cycle sample is already the first post-trigger write.
                        post_cnt_d  = we ? CntW'(POST_DEPTH - 1) : CntW'(POST_DEPTH);
                        state_d     = (we && POST_DEPTH == 1) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (we) begin
                        post_cnt_d = post_cnt_q - CntW'(1);
                        if (post_cnt_q == CntW'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            wrapped_q   <= 1'b0;
            post_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            wrapped_q   <= wrapped_d;
            post_cnt_q  <= post_cnt_d;
            busy_q      <= (state_d == StFill) || (state_d == StPre) || (state_d == StPost);
            done_q      <= (state_d == StDone);
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr_q] <= sample_data;
        end
    end

    // Non-blocking read alongside the write gives read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= read_enable;
            if (read_enable) begin
                rd_data_q <= mem[read_address];
            end
        end
    end

`ifdef CAPTURE_RAM_OREG_EN
    logic [RAM_WIDTH-1:0] oreg_data_q;
    logic                 oreg_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_data_q  <= '0;
            oreg_valid_q <= 1'b0;
        end else begin
            oreg_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                oreg_data_q <= rd_data_q;
            end
        end
    end

    assign read_data  = oreg_data_q;
    assign read_valid = oreg_valid_q;
`else
    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_addr   = wr_addr_q;
    assign trig_addr = trig_addr_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_capture_ram.sv
// Bench for capture_ram: directed scenarios, a stimulus table and a randomized run against
// an abstract model (memory array, phase number and remaining post-trigger count).
module tb_capture_ram;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam int PD = 4;
`ifdef CAPTURE_RAM_OREG_EN
    localparam int RdLat = 2;
`else
    localparam int RdLat = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0, abort = 1'b0, mode = 1'b0, trigger = 1'b0;
    logic          sample_valid = 1'b0, read_enable = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic [AW-1:0] read_address = '0;
    logic [DW-1:0] read_data, d1_read_data;
    logic          read_valid, busy, done, wrapped;
    logic          d1_read_valid, d1_busy, d1_done, d1_wrapped;
    logic [AW-1:0] wr_addr, trig_addr, d1_wr_addr, d1_trig_addr;

    capture_ram #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .POST_DEPTH(PD)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .mode(mode), .trigger(trigger),
        .sample_valid(sample_valid), .sample_data(sample_data), .read_enable(read_enable),
        .read_address(read_address), .read_data(read_data), .read_valid(read_valid),
        .busy(busy), .done(done), .wr_addr(wr_addr), .trig_addr(trig_addr), .wrapped(wrapped)
    );

    capture_ram #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .POST_DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .mode(mode), .trigger(trigger),
        .sample_valid(sample_valid), .sample_data(sample_data), .read_enable(read_enable),
        .read_address(read_address), .read_data(d1_read_data), .read_valid(d1_read_valid),
        .busy(d1_busy), .done(d1_done), .wr_addr(d1_wr_addr), .trig_addr(d1_trig_addr),
        .wrapped(d1_wrapped)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic ab, input logic m, input logic t,
                         input logic sv, input logic [DW-1:0] d);
        arm = a; abort = ab; mode = m; trigger = t; sample_valid = sv; sample_data = d;
    endtask

    task automatic quiet();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        read_enable = 1'b0;
    endtask

    task automatic pulse_reset();
        quiet();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        read_enable = 1'b1;
        read_address = a;
        tick();
        read_enable = 1'b0;
        repeat (RdLat - 1) tick();
        check({name, "_rv"}, 32'(read_valid), 32'd1);
        check(name, 32'(read_data), 32'(exp));
    endtask

    typedef struct {
        logic arm, abort, mode, trig, sv;
        logic [DW-1:0] data;
        logic busy, done, wrapped;
        logic [AW-1:0] wr, ta;
    } vec_t;

    function automatic vec_t mk(input int a, input int ab, input int m, input int t, input int sv,
                                input int d, input int b, input int dn, input int wp,
                                input int wr, input int ta);
        vec_t v;
        v.arm = a[0]; v.abort = ab[0]; v.mode = m[0]; v.trig = t[0]; v.sv = sv[0];
        v.data = d[DW-1:0]; v.busy = b[0]; v.done = dn[0]; v.wrapped = wp[0];
        v.wr = wr[AW-1:0]; v.ta = ta[AW-1:0];
        return v;
    endfunction

    vec_t tbl [19];

    // Abstract model state for the randomized run.
    int             m_ph, m_wr, m_ta, m_rem, m_old;
    bit             m_wrap;
    logic [DW-1:0]  m_mem [D];
    bit             m_kn  [D];
    logic [DW-1:0]  m_rd1, m_rd2;
    bit             m_k1, m_k2, m_rv1, m_rv2;

    initial begin
        //                arm ab m tr sv data   busy dn wp wr ta
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) tbl[i] = mk(0, 0, 0, 0, 1, 8'hA0 + i - 1, 1, 0, 0, i, 0);
        tbl[6]  = mk(1, 1, 0, 0, 1, 8'hEE, 0, 0, 0, 5, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 8'hEE, 0, 0, 0, 5, 0);
        tbl[8]  = mk(0, 0, 0, 1, 1, 8'hEE, 0, 0, 0, 5, 0);
        tbl[9]  = mk(1, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 8'hB0, 1, 0, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 1, 1, 8'hB1, 1, 0, 0, 2, 1);
        tbl[12] = mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 2, 1);
        tbl[13] = mk(0, 0, 0, 0, 1, 8'hB2, 1, 0, 0, 3, 1);
        tbl[14] = mk(0, 0, 0, 0, 1, 8'hB3, 1, 0, 0, 4, 1);
        tbl[15] = mk(0, 0, 0, 0, 1, 8'hB4, 0, 1, 0, 5, 1);
        tbl[16] = mk(0, 0, 0, 0, 1, 8'hEE, 0, 1, 0, 5, 1);
        tbl[17] = mk(1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1);
        tbl[18] = mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1);

        // Reset values, checked before any clock edge.
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wrapped", 32'(wrapped), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_trig_addr", 32'(trig_addr), 0);
        check("rst_read_valid", 32'(read_valid), 0);
        check("rst_read_data", 32'(read_data), 0);
        #2 rst_n = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        tick();
        check("no_write_before_arm", 32'(wr_addr), 0);

        // One-shot fill of all 16 locations.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check("fill_busy", 32'(busy), 1);
        for (int i = 0; i < D; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DW'(i));
            tick();
            if (i == D - 2) check("fill_not_done_early", 32'(done), 0);
        end
        quiet();
        check("fill_done", 32'(done), 1);
        check("fill_busy_low", 32'(busy), 0);
        check("fill_wrapped", 32'(wrapped), 1);
        check("fill_wr_addr", 32'(wr_addr), 0);
        for (int i = 0; i < D; i++) do_read(AW'(i), DW'(i), $sformatf("fill_rd%0d", i));
        tick();
        check("read_valid_drops", 32'(read_valid), 0);

        // Stimulus table: abort-with-arm, ignored trigger, short circular capture.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].arm, tbl[i].abort, tbl[i].mode, tbl[i].trig, tbl[i].sv, tbl[i].data);
            tick();
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("tbl%0d_wrapped", i), 32'(wrapped), 32'(tbl[i].wrapped));
            check($sformatf("tbl%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].wr));
            check($sformatf("tbl%0d_trig_addr", i), 32'(trig_addr), 32'(tbl[i].ta));
        end
        quiet();
        do_read(4'd5, 8'h05, "abort_sample_not_written");
        do_read(4'd0, 8'hB0, "tbl_rd0");
        do_read(4'd1, 8'hB1, "tbl_rd1");

        // Circular capture, POST_DEPTH=4, trigger on the 17th sample.
        pulse_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, i == 16, 1'b1, DW'(i));
            tick();
            if (i == 18) begin
                check("circ_busy_before_last", 32'(busy), 1);
                check("circ_done_before_last", 32'(done), 0);
            end
        end
        quiet();
        check("circ_done", 32'(done), 1);
        check("circ_trig_addr", 32'(trig_addr), 0);
        check("circ_wrapped", 32'(wrapped), 1);
        check("circ_wr_addr", 32'(wr_addr), 4);
        do_read(4'd4, 8'h04, "circ_oldest");
        do_read(4'd0, 8'h10, "circ_first_post");
        do_read(4'd15, 8'h0F, "circ_rd15");

        // POST_DEPTH=1: trigger with a valid sample on the first PRE cycle.
        pulse_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        check("pd1_not_done_in_pre", 32'(d1_done), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        tick();
        quiet();
        check("pd1_done", 32'(d1_done), 1);
        check("pd1_busy", 32'(d1_busy), 0);
        check("pd1_trig_addr", 32'(d1_trig_addr), 0);
        check("pd1_wr_addr", 32'(d1_wr_addr), 1);
        check("pd1_wrapped", 32'(d1_wrapped), 0);
        check("pd1_read_valid", 32'(d1_read_valid), 0);
        check("pd1_read_data", 32'(d1_read_data), 0);
        check("pd4_still_busy", 32'(busy), 1);

        // Same-cycle read and write to address 3 (read-first).
        pulse_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        for (int i = 0; i < D + 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (i == 3) ? 8'hAA : DW'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        read_enable = 1'b1;
        read_address = 4'd3;
        tick();
        quiet();
        repeat (RdLat - 1) tick();
        check("rw_same_cycle_rv", 32'(read_valid), 1);
        check("rw_same_cycle_old", 32'(read_data), 32'h AA);
        do_read(4'd3, 8'h55, "rw_later_new");

        // Asynchronous reset in POST; memory survives.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66);
        tick();
        quiet();
        check("post_busy", 32'(busy), 1);
        read_enable = 1'b1;
        read_address = 4'd3;
        tick();
        tick();
        check("pre_reset_rv", 32'(read_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 0);
        check("async_done", 32'(done), 0);
        check("async_wrapped", 32'(wrapped), 0);
        check("async_wr_addr", 32'(wr_addr), 0);
        check("async_trig_addr", 32'(trig_addr), 0);
        check("async_read_valid", 32'(read_valid), 0);
        check("async_read_data", 32'(read_data), 0);
        #1 rst_n = 1'b1;
        quiet();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
        tick();
        quiet();
        check("post_reset_no_write", 32'(wr_addr), 0);
        do_read(4'd4, 8'h66, "mem_after_reset4");
        do_read(4'd3, 8'h55, "mem_after_reset3");

        // Randomized run against the abstract model.
        pulse_reset();
        m_ph = 0; m_wr = 0; m_ta = 0; m_rem = 0; m_wrap = 0;
        m_rd1 = '0; m_rd2 = '0; m_k1 = 1; m_k2 = 1; m_rv1 = 0; m_rv2 = 0;
        for (int i = 0; i < D; i++) m_kn[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            logic a, ab, m, t, sv, re, w, exp_rv, exp_k;
            logic [DW-1:0] d, exp_rd;
            logic [AW-1:0] ra;
            a  = ($urandom_range(7) == 0);
            ab = ($urandom_range(63) == 0);
            m  = 1'($urandom_range(1));
            t  = ($urandom_range(5) == 0);
            sv = ($urandom_range(3) != 0);
            d  = DW'($urandom_range(255));
            re = 1'($urandom_range(1));
            ra = AW'($urandom_range(D - 1));
            drive(a, ab, m, t, sv, d);
            read_enable = re;
            read_address = ra;

            w = (m_ph >= 1 && m_ph <= 3) && sv && !ab;
            if (m_rv1) begin m_rd2 = m_rd1; m_k2 = m_k1; end
            m_rv2 = m_rv1;
            if (re) begin m_rd1 = m_mem[ra]; m_k1 = m_kn[ra]; end
            m_rv1 = re;
            if (w) begin m_mem[m_wr] = d; m_kn[m_wr] = 1; end
            m_old = m_wr;
            if (ab) begin
                m_ph = 0;
            end else if ((m_ph == 0 || m_ph == 4) && a) begin
                m_wr = 0; m_wrap = 0; m_ph = m ? 2 : 1;
            end else begin
                if (w) begin
                    m_wr = (m_wr + 1) % D;
                    if (m_old == D - 1) m_wrap = 1;
                end
                case (m_ph)
                    1: if (w && m_old == D - 1) m_ph = 4;
                    2: if (t) begin
                        m_ta = m_old;
                        m_rem = PD - (w ? 1 : 0);
                        m_ph = (m_rem == 0) ? 4 : 3;
                    end
                    3: if (w) begin
                        m_rem--;
                        if (m_rem == 0) m_ph = 4;
                    end
                    default: ;
                endcase
            end
            exp_rv = (RdLat == 1) ? m_rv1 : m_rv2;
            exp_rd = (RdLat == 1) ? m_rd1 : m_rd2;
            exp_k  = (RdLat == 1) ? m_k1 : m_k2;

            tick();
            check($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_ph >= 1 && m_ph <= 3));
            check($sformatf("rnd%0d_done", c), 32'(done), 32'(m_ph == 4));
            check($sformatf("rnd%0d_wr_addr", c), 32'(wr_addr), 32'(m_wr));
            check($sformatf("rnd%0d_trig_addr", c), 32'(trig_addr), 32'(m_ta));
            check($sformatf("rnd%0d_wrapped", c), 32'(wrapped), 32'(m_wrap));
            check($sformatf("rnd%0d_read_valid", c), 32'(read_valid), 32'(exp_rv));
            if (exp_k) check($sformatf("rnd%0d_read_data", c), 32'(read_data), 32'(exp_rd));
        end
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
